// File: rtl/bip2_pkg.sv
// Shared definitions for the BIP-II core.
// Contents:
//   - word widths (address/operand, instruction, opcode field)
//   - opcode encodings HLT..JMP
//   - fetch-stage state encoding
package bip2_pkg;

    localparam int ADDR_WIDTH   = 11;
    localparam int INSTR_WIDTH  = 16;
    localparam int OPCODE_WIDTH = 5;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;

    localparam opcode_t HLT  = 5'b00000;
    localparam opcode_t STO  = 5'b00001;
    localparam opcode_t LD   = 5'b00010;
    localparam opcode_t LDI  = 5'b00011;
    localparam opcode_t ADD  = 5'b00100;
    localparam opcode_t ADDI = 5'b00101;
    localparam opcode_t SUB  = 5'b00110;
    localparam opcode_t SUBI = 5'b00111;
    localparam opcode_t BEQ  = 5'b01000;
    localparam opcode_t BNE  = 5'b01001;
    localparam opcode_t BGT  = 5'b01010;
    localparam opcode_t BGE  = 5'b01011;
    localparam opcode_t BLT  = 5'b01100;
    localparam opcode_t BLE  = 5'b01101;
    localparam opcode_t JMP  = 5'b01110;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        LOAD   = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/bip2_pc.sv
// Program counter register for the BIP-II fetch stage.
// Ports:
//   clock_i   in   clock, rising edge
//   reset_i   in   synchronous active-high reset, clears PC to 0
//   load_i    in   load target_i (branch taken); wins over inc_i
//   inc_i     in   advance PC by one, modulo 2^ADDR_WIDTH
//   target_i  in   branch target
//   pc_o      out  current PC
module bip2_pc
    import bip2_pkg::*;
(
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_q;

    // NOTE: default assignment first so every path assigns pc_d; no latch.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            // Natural overflow of the 11-bit add gives the 2047 -> 0 wrap.
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    // NOTE: non-blocking assignment for state so all flops update together.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/bip2_fetch.sv
// BIP-II instruction-fetch stage: FETCH -> LOAD -> EXEC sequencer, instruction
// register, retired-instruction counter and the PC (in bip2_pc).
// Ports:
//   clock_i      in   clock, rising edge
//   reset_i      in   synchronous active-high reset, beats every transition
//   Branch_i     in   decoder: next PC = operand (EXEC only)
//   Wrpc_i       in   decoder: PC write enable (EXEC only)
//   Imem_data_i  in   ROM data, one cycle after Imem_rd_o
//   Imem_addr_o  out  ROM address (= Pc_o)
//   Imem_rd_o    out  ROM read strobe (FETCH)
//   Opcode_o     out  IR[15:11]
//   Operand_o    out  IR[10:0]
//   Pc_o         out  current PC
//   Exec_o       out  decoder outputs are honoured this cycle
//   Halted_o     out  HLT has executed
//   Retired_o    out  instructions that completed EXEC, wraps at 2^16
module bip2_fetch
    import bip2_pkg::*;
(
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    Branch_i,
    input  logic                    Wrpc_i,
    input  logic [INSTR_WIDTH-1:0]  Imem_data_i,
    output logic [ADDR_WIDTH-1:0]   Imem_addr_o,
    output logic                    Imem_rd_o,
    output logic [OPCODE_WIDTH-1:0] Opcode_o,
    output logic [ADDR_WIDTH-1:0]   Operand_o,
    output logic [ADDR_WIDTH-1:0]   Pc_o,
    output logic                    Exec_o,
    output logic                    Halted_o,
    output logic [15:0]             Retired_o
);

    fetch_state_e           state_d, state_q;
    logic [INSTR_WIDTH-1:0] ir_d, ir_q;
    logic [15:0]            retired_d, retired_q;
    logic                   exec_d, exec_q;
    logic                   halted_d, halted_q;
    logic                   rd_d, rd_q;
    logic                   pc_load;
    logic                   pc_inc;
    logic [ADDR_WIDTH-1:0]  pc;

    assign Opcode_o  = ir_q[INSTR_WIDTH-1:ADDR_WIDTH];
    assign Operand_o = ir_q[ADDR_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;

        case (state_q)
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                ir_d    = Imem_data_i;
                state_d = EXEC;
            end
            EXEC: begin
                retired_d = retired_q + 16'd1;
                if (Opcode_o == HLT) begin
                    state_d = HALTED;
                end else begin
                    state_d = FETCH;
                    // With Wrpc_i low the PC holds and the same word is refetched.
                    if (Wrpc_i) begin
                        pc_load = Branch_i;
                        pc_inc  = ~Branch_i;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Outputs are registered copies of the next-state decode, so they
        // line up with state_q without any input-to-output path.
        exec_d   = (state_d == EXEC);
        halted_d = (state_d == HALTED);
        rd_d     = (state_d == FETCH);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            retired_q <= '0;
            exec_q    <= 1'b0;
            halted_q  <= 1'b0;
            rd_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            exec_q    <= exec_d;
            halted_q  <= halted_d;
            rd_q      <= rd_d;
        end
    end

    // Reset inside bip2_pc discards any PC update requested in the same cycle.
    bip2_pc u_pc (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .load_i   (pc_load),
        .inc_i    (pc_inc),
        .target_i (Operand_o),
        .pc_o     (pc)
    );

    assign Pc_o        = pc;
    assign Imem_addr_o = pc;
    assign Imem_rd_o   = rd_q;
    assign Exec_o      = exec_q;
    assign Halted_o    = halted_q;
    assign Retired_o   = retired_q;

endmodule

// File: doc/bip2_fetch.md
# bip2_fetch

Instruction-fetch stage of the BIP-II processor, directly upstream of the control decoder. Holds the program counter and instruction register, reads 16-bit instructions from a synchronous instruction ROM, and splits each one into a 5-bit opcode for the decoder and an 11-bit operand. Consumes the decoder's `Branch` and `Wrpc` controls to choose the next PC, and latches a halted state on HLT.

## Interface
- `ADDR_WIDTH`, 11, PC / operand width.
- `INSTR_WIDTH`, 16, instruction word width.
- `OPCODE_WIDTH`, 5, opcode field width, `INSTR_WIDTH = OPCODE_WIDTH + ADDR_WIDTH`.
- `clock_i`  in  1  single clock; all state changes on its rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `Branch_i`  in  1  from decoder: next PC = operand.
- `Wrpc_i`  in  1  from decoder: PC write enable.
- `Imem_data_i`  in  16  ROM read data, valid one cycle after `Imem_rd_o`.
- `Imem_addr_o`  out  11  ROM address, always equal to `Pc_o`.
- `Imem_rd_o`  out  1  ROM read strobe.
- `Opcode_o`  out  5  `IR[15:11]`, to decoder `Opcode_i`.
- `Operand_o`  out  11  `IR[10:0]`, to datapath and branch target.
- `Pc_o`  out  11  current PC.
- `Exec_o`  out  1  opcode valid; decoder outputs are honoured this cycle.
- `Halted_o`  out  1  HLT executed; core stopped.
- `Retired_o`  out  16  count of instructions that completed EXEC.

## Operation
- FSM states: FETCH, LOAD, EXEC, HALTED.
- FETCH: `Imem_rd_o=1`, address `=PC`. Next state is LOAD.
- LOAD: `Imem_data_i` is valid; `IR <= Imem_data_i` at end of cycle. Next state is EXEC.
- EXEC: `Exec_o=1`; decoder combinationally drives `Branch_i`/`Wrpc_i` from `Opcode_o`. At the end of the cycle:
  - If `Opcode_o == HLT (5'b00000)`: go to HALTED. PC and IR are unchanged. `Retired_o` increments.
  - Otherwise, if `Wrpc_i=1`: `PC <= Branch_i ? Operand_o : PC+1`. Then go to FETCH. `Retired_o` increments.
  - Otherwise, if `Wrpc_i=0`: PC holds and the same address is refetched. Then go to FETCH. `Retired_o` increments.
- HALTED: absorbing state. Only `reset_i` leaves it. `Halted_o=1`, `Imem_rd_o=0`, `Exec_o=0`.
- `Branch_i`/`Wrpc_i` are ignored outside EXEC.
- PC arithmetic is modulo 2^11: 2047+1 wraps to 0. Branch target is `Operand_o` unmodified.
- `Retired_o` wraps from 65535 to 0.
- `Opcode_o`/`Operand_o` always reflect IR, including outside EXEC. Consumers must qualify with `Exec_o`.

## Timing
- Reset values: PC=0, IR=0 (so `Opcode_o=0`, `Operand_o=0`), state=FETCH, `Exec_o=0`, `Halted_o=0`, `Retired_o=0`.
  - In the cycle after reset deassertion: `Imem_rd_o=1`, `Imem_addr_o=0`.
- Reset takes priority over every transition in every state, including mid-EXEC and HALTED. A pending PC update is discarded.
- Throughput is one instruction per 3 cycles: FETCH, LOAD, EXEC.
  - The first EXEC is the 3rd cycle after reset release.
- The ROM contract is exactly one-cycle read latency. `Imem_data_i` is sampled only in LOAD.
- New PC is visible on `Pc_o`/`Imem_addr_o` in the FETCH cycle following EXEC.
- `Halted_o` rises in the cycle after HLT's EXEC.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Structure
- Shared package `bip2_pkg`:
  - opcode constants: HLT, STO, LD, LDI, ADD, ADDI, SUB, SUBI, BEQ, BNE, BGT, BGE, BLT, BLE, JMP = 5'b00000..5'b01110;
  - `ADDR_WIDTH`, `INSTR_WIDTH` and `OPCODE_WIDTH` constants;
  - fetch state enum.
- One sub-module: `bip2_pc`, holding the PC register with synchronous reset, load-operand, increment-with-wrap and hold.
- FSM, IR and retire counter live in `bip2_fetch`.

## Test plan
- Reset then sequential program: ROM[0]=LDI 5, ROM[1]=ADDI 3, ROM[2]=HLT, with the decoder attached.
  - Required: addresses 0,1,2 are fetched in cycles 1,4,7.
  - `Halted_o=1` from cycle 10.
  - `Retired_o=3`; PC frozen at 2.
- Branch taken: ROM[4]=JMP 0x200.
  - Required: the next FETCH has `Imem_addr_o=0x200`.
  - Repeat with BEQ, `z_i=0`: next address is 5.
- Wrap-around: PC preset to 2047 via JMP 2047, ROM[2047]=ADDI 1.
  - Required: next fetch address is 0.
- `Wrpc_i=0` in EXEC on a non-HLT opcode (forced by the bench).
  - Required: same address refetched.
  - `Retired_o` increments by 1.
- Reset asserted during EXEC of JMP 0x100, and again while HALTED.
  - Required: next cycle state=FETCH, `Imem_addr_o=0`, `Halted_o=0`, `Retired_o=0`.
  - The branch is not taken.
